// File: rtl/ow_presence_responder.sv
// ow_presence_responder
//
// 1-Wire slave front end. It watches the open-drain bus for a master reset
// pulse and accepts it only if the low time is long enough. It then waits a
// programmable gap, drives a presence pulse and reports completion to the
// ROM/function layer. All timing is given in microseconds and scaled by
// CLK_PER_US.
//
// Optional build feature: define OW_OVERDRIVE_EN to add the od_mode input and
// the overdrive timing set (OD_RST_MIN_US, OD_WAIT_US, OD_PRESENCE_US).
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   en             responder enable; low aborts to IDLE
//   bus_in         sampled 1-Wire line level (pulled-up wire)
//   od_mode        overdrive select (OW_OVERDRIVE_EN builds only)
//   bus_pull_low   1 = drive the line low (open-drain enable)
//   reset_seen     one-cycle pulse when a valid reset pulse ends
//   presence_done  one-cycle pulse when the presence sequence completes
//   busy           high in any state other than IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus released, waiting for the line to go low
// MEASURE  | line low, counting its width to qualify a master reset
// WAIT     | reset accepted, waiting the gap before presence
// PRESENCE | driving the presence pulse
// RELEASE  | presence released, waiting for the line to float high

module ow_presence_responder #(
    parameter int CLK_PER_US     = 1,
    parameter int RST_MIN_US     = 480,
    parameter int WAIT_US        = 15,
    parameter int PRESENCE_US    = 60,
`ifdef OW_OVERDRIVE_EN
    parameter int OD_RST_MIN_US  = 48,
    parameter int OD_WAIT_US     = 2,
    parameter int OD_PRESENCE_US = 8,
`endif
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bus_in,
`ifdef OW_OVERDRIVE_EN
    input  logic od_mode,
`endif
    output logic bus_pull_low,
    output logic reset_seen,
    output logic presence_done,
    output logic busy
);

    localparam logic [CNT_W-1:0] RST_T     = CNT_W'(RST_MIN_US * CLK_PER_US);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_US * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] PRES_LAST = CNT_W'(PRESENCE_US * CLK_PER_US - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEASURE  = 3'd1,
        ST_WAIT     = 3'd2,
        ST_PRESENCE = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    state_t           state;
    logic [1:0]       bus_sync;
    logic             bus_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rst_lim;
    logic [CNT_W-1:0] wait_lim;
    logic [CNT_W-1:0] pres_lim;

    assign bus_s   = bus_sync[1];
    assign busy    = (state != ST_IDLE);
    // Saturating increment: a master holding the line forever must not wrap
    // the count back below the reset threshold.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef OW_OVERDRIVE_EN
    localparam logic [CNT_W-1:0] OD_RST_T     = CNT_W'(OD_RST_MIN_US * CLK_PER_US);
    localparam logic [CNT_W-1:0] OD_WAIT_LAST = CNT_W'(OD_WAIT_US * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] OD_PRES_LAST = CNT_W'(OD_PRESENCE_US * CLK_PER_US - 1);

    // Latched when leaving IDLE so a mid-sequence od_mode change is ignored.
    logic od_sel;

    assign rst_lim  = od_sel ? OD_RST_T     : RST_T;
    assign wait_lim = od_sel ? OD_WAIT_LAST : WAIT_LAST;
    assign pres_lim = od_sel ? OD_PRES_LAST : PRES_LAST;
`else
    assign rst_lim  = RST_T;
    assign wait_lim = WAIT_LAST;
    assign pres_lim = PRES_LAST;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus_sync      <= 2'b11;
            cnt           <= '0;
            bus_pull_low  <= 1'b0;
            reset_seen    <= 1'b0;
            presence_done <= 1'b0;
`ifdef OW_OVERDRIVE_EN
            od_sel        <= 1'b0;
`endif
        end else begin
            bus_sync      <= {bus_sync[0], bus_in};
            reset_seen    <= 1'b0;
            presence_done <= 1'b0;
            if (!en) begin
                state        <= ST_IDLE;
                cnt          <= '0;
                bus_pull_low <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        bus_pull_low <= 1'b0;
                        if (!bus_s) begin
                            cnt   <= '0;
                            state <= ST_MEASURE;
`ifdef OW_OVERDRIVE_EN
                            od_sel <= od_mode;
`endif
                        end
                    end
                    ST_MEASURE: begin
                        if (!bus_s) begin
                            cnt <= cnt_inc;
                        end else if (cnt >= rst_lim) begin
                            reset_seen <= 1'b1;
                            cnt        <= '0;
                            state      <= ST_WAIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_WAIT: begin
                        if (!bus_s) begin
                            // Master pulled low again: treat it as a fresh reset.
                            cnt   <= '0;
                            state <= ST_MEASURE;
                        end else if (cnt == wait_lim) begin
                            cnt          <= '0;
                            bus_pull_low <= 1'b1;
                            state        <= ST_PRESENCE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_PRESENCE: begin
                        // Our own pull shows up on bus_s here, so it is not looked at.
                        if (cnt == pres_lim) begin
                            cnt          <= '0;
                            bus_pull_low <= 1'b0;
                            state        <= ST_RELEASE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_RELEASE: begin
                        if (bus_s) begin
                            presence_done <= 1'b1;
                            cnt           <= '0;
                            state         <= ST_IDLE;
                        end else begin
                            cnt <= cnt_inc;
                            // Line held low long enough to be a new master reset;
                            // the low time already counted carries into MEASURE.
                            if (cnt_inc >= rst_lim) begin
                                state <= ST_MEASURE;
                            end
                        end
                    end
                    default: begin
                        state        <= ST_IDLE;
                        cnt          <= '0;
                        bus_pull_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ow_presence_responder.sv
// Testbench for ow_presence_responder. The wire is modelled as open-drain:
// the line is low if the bench master or the DUT pulls it. A monitor turns DUT
// output activity into events and matches them against an expected-event
// queue filled by the stimulus before each sequence.

module tb_ow_presence_responder;

    localparam int EV_RS   = 1;
    localparam int EV_RISE = 2;
    localparam int EV_FALL = 3;
    localparam int EV_DONE = 4;
    localparam int DT_ANY  = -1;
    localparam int DT_LE3  = -2;

    typedef struct {
        int kind;
        int dt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic bus_drv;
    logic bus_in;
    logic bus_pull_low;
    logic reset_seen;
    logic presence_done;
    logic busy;
`ifdef OW_OVERDRIVE_EN
    logic od_mode;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_cyc = 0;
    exp_t exp_q[$];

    assign bus_in = bus_drv & ~bus_pull_low;

    always #5 clk = ~clk;

    ow_presence_responder dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .bus_in        (bus_in),
`ifdef OW_OVERDRIVE_EN
        .od_mode       (od_mode),
`endif
        .bus_pull_low  (bus_pull_low),
        .reset_seen    (reset_seen),
        .presence_done (presence_done),
        .busy          (busy)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int kind, input int dt);
        exp_t e;
        e.kind = kind;
        e.dt   = dt;
        exp_q.push_back(e);
    endtask

    task automatic on_event(input int kind);
        exp_t e;
        int   delta;
        delta    = cyc - last_cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
            check_val("unexpected_event", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check_val("event_kind", kind, e.kind);
            if (e.dt >= 0)
                check_val("event_delay", delta, e.dt);
            else if (e.dt == DT_LE3)
                check_val("event_delay_le3", int'(delta <= 3), 1);
        end
    endtask

    // Output monitor
    initial begin
        logic rs_prev, done_prev, pull_prev;
        rs_prev = 1'b0; done_prev = 1'b0; pull_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (reset_seen) begin
                    check_val("reset_seen_width", int'(rs_prev), 0);
                    on_event(EV_RS);
                end
                if (presence_done) begin
                    check_val("presence_done_width", int'(done_prev), 0);
                    on_event(EV_DONE);
                end
                if (bus_pull_low && !pull_prev) on_event(EV_RISE);
                if (!bus_pull_low && pull_prev) on_event(EV_FALL);
            end
            rs_prev   = reset_seen;
            done_prev = presence_done;
            pull_prev = bus_pull_low;
        end
    end

    task automatic pulse_low(input int len);
        bus_drv = 1'b0;
        repeat (len) @(negedge clk);
        bus_drv = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check_val("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_rs(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (reset_seen) break;
        end
        check_val("reset_seen_timeout", int'(reset_seen), 1);
    endtask

    task automatic wait_rise(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_pull_low) break;
        end
        check_val("presence_timeout", int'(bus_pull_low), 1);
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge clk);
        check_val(tag, exp_q.size(), 0);
        exp_q.delete();
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_pull"}, int'(bus_pull_low), 0);
    endtask

    task automatic valid_reset(input int len, input string tag);
        push_exp(EV_RS, DT_ANY);
        push_exp(EV_RISE, 15);
        push_exp(EV_FALL, 60);
        push_exp(EV_DONE, DT_LE3);
        pulse_low(len);
        wait_idle(300);
        drain(tag);
    endtask

    task automatic ignored_low(input int len, input string tag);
        pulse_low(len);
        wait_idle(20);
        repeat (30) @(negedge clk);
        drain(tag);
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        bus_drv = 1'b1;
`ifdef OW_OVERDRIVE_EN
        od_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_val("rst_pull", int'(bus_pull_low), 0);
        check_val("rst_reset_seen", int'(reset_seen), 0);
        check_val("rst_done", int'(presence_done), 0);
        check_val("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        valid_reset(500, "valid_500");
        ignored_low(100, "short_100");
        valid_reset(485, "valid_485");
        ignored_low(470, "short_470");

        // Master re-issues reset during the wait gap: one presence only.
        push_exp(EV_RS, DT_ANY);
        push_exp(EV_RS, DT_ANY);
        push_exp(EV_RISE, 15);
        push_exp(EV_FALL, 60);
        push_exp(EV_DONE, DT_LE3);
        pulse_low(500);
        wait_rs(20);
        repeat (5) @(negedge clk);
        pulse_low(490);
        wait_idle(300);
        drain("rereset_wait");

        // Abort 20 cycles into presence.
        push_exp(EV_RS, DT_ANY);
        push_exp(EV_RISE, 15);
        push_exp(EV_FALL, DT_ANY);
        pulse_low(500);
        wait_rise(40);
        repeat (20) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check_val("abort_pull", int'(bus_pull_low), 0);
        check_val("abort_busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        en = 1'b1;
        drain("abort");

        // Disabled responder ignores a valid-length reset.
        en = 1'b0;
        bus_drv = 1'b0;
        repeat (50) @(negedge clk);
        check_val("disabled_busy", int'(busy), 0);
        repeat (450) @(negedge clk);
        bus_drv = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b1;
        drain("disabled");

        // Synchronous reset in the middle of MEASURE.
        bus_drv = 1'b0;
        repeat (100) @(negedge clk);
        check_val("measure_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_pull", int'(bus_pull_low), 0);
        check_val("midrst_reset_seen", int'(reset_seen), 0);
        check_val("midrst_done", int'(presence_done), 0);
        check_val("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        bus_drv = 1'b1;
        repeat (10) @(negedge clk);
        valid_reset(500, "after_midrst");

`ifdef OW_OVERDRIVE_EN
        // Overdrive timing; od_mode flips mid-sequence and must be ignored.
        push_exp(EV_RS, DT_ANY);
        push_exp(EV_RISE, 2);
        push_exp(EV_FALL, 8);
        push_exp(EV_DONE, DT_LE3);
        od_mode = 1'b1;
        bus_drv = 1'b0;
        repeat (10) @(negedge clk);
        od_mode = 1'b0;
        repeat (40) @(negedge clk);
        bus_drv = 1'b1;
        wait_idle(100);
        drain("od_50");
        ignored_low(50, "std_50");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
